if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the decode stage. Holds the fetch PC, issues word requests to instruction memory over a req/ack handshake, and owns the IF/ID pipeline register (instruction, its PC, valid). It absorbs memory wait states, holds a fetched word while decode stalls, and takes branch redirects from decode, flushing wrong-path instructions.

## Interface
- PC_RESET, 16'h0000, first fetch address after reset
- NOP_INST, 16'h0000, instruction word inserted as a bubble
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard hold: IF/ID must not change
- br_perform  in  1  decode resolved a taken branch this cycle
- pc_branched  in  16  branch target from decode
- imem_req  out  1  fetch request
- imem_addr  out  16  word address of request
- imem_ack  in  1  imem_data valid this cycle; completes request
- imem_data  in  16  instruction word
- inst  out  16  IF/ID instruction
- pc  out  16  IF/ID: address of inst
- valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: fetch_pc[15:0], redir_pc[15:0], hold_inst/hold_pc, state {FETCH, HOLD, DROP}, IF/ID {inst, pc, valid}.
- Memory protocol: imem_req and imem_addr stay stable from assertion until the imem_ack cycle. Same-cycle ack (zero wait) is legal. imem_req = 1 in FETCH and DROP; imem_addr = fetch_pc; imem_req = 0 in HOLD and while rst.
- redirect = br_perform & ~stall. With stall high, br_perform is ignored.
- FETCH, no redirect:
  - ack & ~stall: IF/ID <= {imem_data, fetch_pc, 1}; fetch_pc += 1.
  - ack & stall: hold <= {imem_data, fetch_pc}; fetch_pc += 1; go to HOLD. IF/ID unchanged.
  - no ack: IF/ID <= bubble unless stall (then unchanged).
- HOLD: no request. When ~stall, IF/ID <= {hold_inst, hold_pc, 1} and go to FETCH.
- FETCH with redirect:
  - IF/ID <= {NOP_INST, pc unchanged, 0}.
  - If ack this cycle: data discarded; fetch_pc <= pc_branched; stay in FETCH.
  - If no ack: redir_pc <= pc_branched; go to DROP.
- HOLD with redirect: hold discarded; IF/ID <= bubble; fetch_pc <= pc_branched; go to FETCH.
- DROP: keeps the outstanding request at the old fetch_pc.
  - On ack: data discarded; fetch_pc <= redir_pc; go to FETCH.
  - IF/ID <= bubble unless stall.
  - A further redirect in DROP overwrites redir_pc (latest wins).
- PC arithmetic is modulo 2^16: 16'hFFFF + 1 = 16'h0000.
- Reset values: fetch_pc = PC_RESET, state = FETCH, inst = NOP_INST, pc = 16'h0000, valid = 0, hold/redir_pc = 0.
- rst asserted mid-request abandons it. The memory must accept a dropped req.

## Timing
- All outputs except imem_req/imem_addr are registered. imem_req/imem_addr are decoded from state/fetch_pc, with no combinational path from imem_ack.
- First request is in the cycle after rst deasserts.
- Zero-wait memory: one instruction per cycle; IF/ID updates at the edge ending the ack cycle.
- N wait states: N bubbles into IF/ID per instruction.
- Branch: redirect at edge t gives a bubble in IF/ID after t. Target is requested in cycle t+1 and appears in IF/ID after t+1 (zero wait): a 1-bubble penalty. From DROP, the penalty grows by the remaining wait of the dropped request plus the target's fetch.
- Stall: IF/ID frozen for every stalled edge. At most one extra word is buffered (HOLD); no new request is issued until the stall releases.

## Test plan
- Reset: hold rst 3 cycles with PC_RESET = 16'h0010 -> valid = 0, inst = 0, imem_req = 0. After release, imem_addr = 16'h0010 with req = 1.
- Straight line, zero-wait memory returning data = addr ^ 16'hA5A5 -> consecutive cycles show pc = 10, 11, 12… with matching inst and valid = 1. A run started at 16'hFFFE wraps to 16'h0000.
- 2 wait states per access -> each instruction is followed by 2 bubbles (valid = 0). imem_addr is stable until ack.
- stall for 3 cycles while ack arrives for addr 16'h0013 -> IF/ID holds 16'h0012's word, req drops. After release, 16'h0013 enters IF/ID next edge, then the fetch of 16'h0014 proceeds; no loss or duplication.
- br_perform = 1, pc_branched = 16'h0040 during a zero-wait fetch -> next IF/ID is a bubble, then pc = 16'h0040 valid. br_perform with stall = 1 -> no redirect.
- Redirect to 16'h0080 while a 3-wait request to 16'h0021 is outstanding -> req/addr 16'h0021 held until ack and its data is never valid. The next request is 16'h0080, which reaches IF/ID with valid = 1.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: fetch PC, imem req/ack, IF/ID register
module if_stage #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_perform,
  input  logic [15:0] pc_branched,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] inst,
  output logic [15:0] pc,
  output logic        valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [15:0] fetch_pc, fetch_pc_n;
  logic [15:0] redir_pc, redir_pc_n;
  logic [15:0] hold_inst, hold_inst_n;
  logic [15:0] hold_pc, hold_pc_n;
  logic [15:0] inst_n, pc_n;
  logic        valid_n;
  logic        redirect;

  // A stalled decode cannot consume a branch, so a branch under stall is ignored.
  assign redirect = br_perform & ~stall;

  // Request is decoded from registered state only, so it never depends on imem_ack.
  assign imem_req  = ~rst & (state != HOLD);
  assign imem_addr = fetch_pc;

  // Next-state and next-register computation for the fetch FSM and IF/ID.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    redir_pc_n  = redir_pc;
    hold_inst_n = hold_inst;
    hold_pc_n   = hold_pc;
    inst_n      = inst;
    pc_n        = pc;
    valid_n     = valid;
    case (state)
      FETCH: begin
        if (redirect) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
          if (imem_ack) begin
            fetch_pc_n = pc_branched;
          end else begin
            redir_pc_n = pc_branched;
            state_n    = DROP;
          end
        end else if (imem_ack) begin
          fetch_pc_n = fetch_pc + 16'd1;
          if (stall) begin
            hold_inst_n = imem_data;
            hold_pc_n   = fetch_pc;
            state_n     = HOLD;
          end else begin
            inst_n  = imem_data;
            pc_n    = fetch_pc;
            valid_n = 1'b1;
          end
        end else if (!stall) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          inst_n     = NOP_INST;
          valid_n    = 1'b0;
          fetch_pc_n = pc_branched;
          state_n    = FETCH;
        end else if (!stall) begin
          inst_n  = hold_inst;
          pc_n    = hold_pc;
          valid_n = 1'b1;
          state_n = FETCH;
        end
      end
      DROP: begin
        // The outstanding wrong-path request must complete before the target is fetched.
        if (!stall) begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
        end
        if (redirect) begin
          redir_pc_n = pc_branched;
        end
        if (imem_ack) begin
          fetch_pc_n = redirect ? pc_branched : redir_pc;
          state_n    = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      fetch_pc  <= PC_RESET;
      redir_pc  <= 16'h0000;
      hold_inst <= 16'h0000;
      hold_pc   <= 16'h0000;
      inst      <= NOP_INST;
      pc        <= 16'h0000;
      valid     <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      redir_pc  <= redir_pc_n;
      hold_inst <= hold_inst_n;
      hold_pc   <= hold_pc_n;
      inst      <= inst_n;
      pc        <= pc_n;
      valid     <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_perform;
  logic [15:0] pc_branched;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic [15:0] pc;
  logic        valid;

  int npass = 0;
  int ntotal = 0;
  int ninst = 0;
  int waits = 0;

  if_stage #(.PC_RESET(16'h0010), .NOP_INST(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_perform(br_perform),
    .pc_branched(pc_branched), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst(inst), .pc(pc), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_if(input logic [15:0] exp_pc);
    chk("if_valid", {31'd0, valid}, 32'd1);
    chk("if_pc", {16'd0, pc}, {16'd0, exp_pc});
    chk("if_inst", {16'd0, inst}, {16'd0, exp_pc ^ 16'hA5A5});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory: answers each request after 'waits' extra cycles with addr ^ A5A5.
  int wcnt = 0;
  always @(posedge clk) begin
    #3;
    if (imem_req) begin
      if (wcnt >= waits) begin
        imem_ack  = 1'b1;
        imem_data = imem_addr ^ 16'hA5A5;
        wcnt      = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        wcnt++;
      end
    end else begin
      imem_ack  = 1'b0;
      imem_data = 16'hDEAD;
      wcnt      = 0;
    end
  end

  // Scoreboard: the stream of valid IF/ID entries must be the program-order
  // sequence of addresses, restarting at each taken branch target.
  logic        started = 1'b0;
  logic        p_rst, p_stall, p_br, p_req, p_ack, p_valid;
  logic [15:0] p_target, p_addr, p_inst, p_pc;
  logic [15:0] model_pc = 16'h0010;

  always @(negedge clk) begin
    if (started) begin
      if (p_rst) begin
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_inst", {16'd0, inst}, 32'd0);
        chk("rst_pc", {16'd0, pc}, 32'd0);
        model_pc = 16'h0010;
      end else if (p_stall) begin
        chk("stall_frozen", {valid, inst, pc}, {p_valid, p_inst, p_pc});
      end else if (p_br) begin
        chk("redirect_bubble", {31'd0, valid}, 32'd0);
        model_pc = p_target;
      end else if (valid) begin
        chk("stream_pc", {16'd0, pc}, {16'd0, model_pc});
        chk("stream_inst", {16'd0, inst}, {16'd0, model_pc ^ 16'hA5A5});
        model_pc = model_pc + 16'd1;
        ninst++;
      end else begin
        chk("bubble_inst", {16'd0, inst}, 32'd0);
      end
      if (rst) chk("req_in_rst", {31'd0, imem_req}, 32'd0);
      else if (!p_rst && p_req && !p_ack)
        chk("req_stable", {imem_req, imem_addr}, {1'b1, p_addr});
    end
    p_rst    = rst;
    p_stall  = stall;
    p_br     = br_perform;
    p_target = pc_branched;
    p_req    = imem_req;
    p_ack    = imem_ack;
    p_addr   = imem_addr;
    p_valid  = valid;
    p_inst   = inst;
    p_pc     = pc;
    started  = 1'b1;
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br_perform = 1'b0; pc_branched = 16'h0000;
    imem_ack = 1'b0; imem_data = 16'hDEAD; waits = 0;

    // reset held for three edges
    tick; tick; tick;
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_inst", {16'd0, inst}, 32'd0);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req", {imem_req, imem_addr}, {1'b1, 16'h0010});

    // zero-wait straight line
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_if(16'h0010 + 16'(i));
    end

    // stall across the ack of 0x13
    stall = 1'b1;
    tick; chk_if(16'h0012); chk("hold_req", {31'd0, imem_req}, 32'd0);
    tick; chk_if(16'h0012); chk("hold_req", {31'd0, imem_req}, 32'd0);
    tick; chk_if(16'h0012); chk("hold_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick; chk_if(16'h0013); chk("after_hold_req", {imem_req, imem_addr}, {1'b1, 16'h0014});
    tick; chk_if(16'h0014);

    // taken branch during zero-wait fetch
    br_perform = 1'b1; pc_branched = 16'h0040;
    tick; chk("br_bubble", {31'd0, valid}, 32'd0);
    br_perform = 1'b0;
    tick; chk_if(16'h0040);

    // branch under stall is ignored
    stall = 1'b1; br_perform = 1'b1; pc_branched = 16'h0099;
    tick; chk_if(16'h0040);
    stall = 1'b0; br_perform = 1'b0;
    tick; chk_if(16'h0041);
    tick; chk_if(16'h0042);

    // wrap-around run from 0xFFFE
    br_perform = 1'b1; pc_branched = 16'hFFFE;
    tick; chk("br_bubble", {31'd0, valid}, 32'd0);
    br_perform = 1'b0;
    tick; chk_if(16'hFFFE);
    tick; chk_if(16'hFFFF);
    tick; chk_if(16'h0000);
    tick; chk_if(16'h0001);

    // two wait states: two bubbles per instruction
    waits = 2;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("ws_bubble", {31'd0, valid}, 32'd0);
      chk("ws_addr", {imem_req, imem_addr}, {1'b1, 16'h0002 + 16'(k)});
      tick;
      chk("ws_bubble", {31'd0, valid}, 32'd0);
      chk("ws_addr", {imem_req, imem_addr}, {1'b1, 16'h0002 + 16'(k)});
      tick;
      chk_if(16'h0002 + 16'(k));
    end

    // move to 0x20, then redirect while the 3-wait fetch of 0x21 is outstanding
    waits = 0; br_perform = 1'b1; pc_branched = 16'h0020;
    tick; chk("br_bubble", {31'd0, valid}, 32'd0);
    br_perform = 1'b0;
    tick; chk_if(16'h0020);
    waits = 3; br_perform = 1'b1; pc_branched = 16'h0070;
    tick; chk("drop_bubble", {31'd0, valid}, 32'd0);
    chk("drop_addr", {imem_req, imem_addr}, {1'b1, 16'h0021});
    pc_branched = 16'h0080;
    tick; chk("drop_bubble", {31'd0, valid}, 32'd0);
    chk("drop_addr", {imem_req, imem_addr}, {1'b1, 16'h0021});
    br_perform = 1'b0;
    tick; chk("drop_bubble", {31'd0, valid}, 32'd0);
    chk("drop_addr", {imem_req, imem_addr}, {1'b1, 16'h0021});
    tick; chk("drop_bubble", {31'd0, valid}, 32'd0);
    chk("target_addr", {imem_req, imem_addr}, {1'b1, 16'h0080});
    waits = 0;
    tick; chk_if(16'h0080);
    tick; chk_if(16'h0081);

    // reset abandons an outstanding request
    waits = 2;
    tick; chk("pre_rst_addr", {imem_req, imem_addr}, {1'b1, 16'h0082});
    rst = 1'b1;
    #1; chk("rst_req_low", {31'd0, imem_req}, 32'd0);
    tick; chk("rst2_valid", {31'd0, valid}, 32'd0);
    chk("rst2_pc", {16'd0, pc}, 32'd0);
    rst = 1'b0; waits = 0;
    #1; chk("rst2_first_req", {imem_req, imem_addr}, {1'b1, 16'h0010});
    tick; chk_if(16'h0010);

    // random mix of stalls, branches and wait states, checked by the scoreboard
    ninst = 0;
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      br_perform  = ($urandom_range(0, 7) == 0);
      pc_branched = 16'($urandom);
      waits       = $urandom_range(0, 2);
      tick;
    end
    stall = 1'b0; br_perform = 1'b0; waits = 0;
    tick; tick; tick; tick;
    chk("progress", {31'd0, ninst > 40}, 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
